// File: rtl/vm_text_writer.sv
// Write side of the text-mode video memory: turns a byte stream into glyph,
// erase, row-clear and screen-clear writes on VM port A while tracking a cursor.
module vm_text_writer #(
  parameter int unsigned ROWS  = 30,
  parameter int unsigned COLS  = 32,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  output logic        char_ready,
  output logic        vm_we,
  output logic [11:0] vm_addr,
  output logic [7:0]  vm_din,
  output logic        busy,
  output logic [4:0]  cur_row,
  output logic [4:0]  cur_col
);

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [4:0] LAST_COL = 5'(COLS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLR_ROW    = 2'd1,
    CLR_SCREEN = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic [9:0]  clr_idx_r;
  logic [9:0]  clr_idx_nx_s;
  logic [4:0]  row_r;
  logic [4:0]  row_nx_s;
  logic [4:0]  col_r;
  logic [4:0]  col_nx_s;
  logic        vm_we_r;
  logic        vm_we_nx_s;
  logic [11:0] vm_addr_r;
  logic [11:0] vm_addr_nx_s;
  logic [7:0]  vm_din_r;
  logic [7:0]  vm_din_nx_s;

  logic        printable_s;
  logic        col_last_s;
  logic        clr_col_last_s;
  logic        clr_row_last_s;

  // Cursor row advance with wrap from the last visible row back to the top.
  function automatic logic [4:0] next_row(input logic [4:0] r);
    if (r == LAST_ROW) begin
      return 5'd0;
    end else begin
      return r + 5'd1;
    end
  endfunction

  // clr_idx is kept in {row, col} form so it doubles as the cell address.
  assign printable_s    = (char_data >= 8'h20) && (char_data <= 8'h7E);
  assign col_last_s     = (col_r == LAST_COL);
  assign clr_col_last_s = (clr_idx_r[4:0] == LAST_COL);
  assign clr_row_last_s = (clr_idx_r[9:5] == LAST_ROW);

  // State register; reset parks in CLR_SCREEN so a full clear follows release.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state_r <= CLR_SCREEN;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (char_valid) begin
          case (char_data)
            CH_LF:   state_nx_s = CLR_ROW;
            CH_FF:   state_nx_s = CLR_SCREEN;
            default: begin
              if (printable_s && col_last_s) begin
                state_nx_s = CLR_ROW;
              end else begin
                state_nx_s = IDLE;
              end
            end
          endcase
        end else begin
          state_nx_s = IDLE;
        end
      end
      CLR_ROW: begin
        if (clr_col_last_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = CLR_ROW;
        end
      end
      CLR_SCREEN: begin
        if (clr_col_last_s && clr_row_last_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = CLR_SCREEN;
        end
      end
      default: state_nx_s = CLR_SCREEN;
    endcase
  end

  // Write port, cursor and clear-index next values.
  always_comb begin
    vm_we_nx_s   = 1'b0;
    vm_addr_nx_s = vm_addr_r;
    vm_din_nx_s  = vm_din_r;
    row_nx_s     = row_r;
    col_nx_s     = col_r;
    clr_idx_nx_s = clr_idx_r;
    case (state_r)
      IDLE: begin
        if (char_valid) begin
          case (char_data)
            CH_LF: begin
              col_nx_s     = 5'd0;
              row_nx_s     = next_row(row_r);
              clr_idx_nx_s = 10'd0;
            end
            CH_CR: begin
              col_nx_s = 5'd0;
            end
            CH_BS: begin
              if (col_r != 5'd0) begin
                col_nx_s     = col_r - 5'd1;
                vm_we_nx_s   = 1'b1;
                vm_addr_nx_s = {2'b00, row_r, col_r - 5'd1};
                vm_din_nx_s  = BLANK;
              end else begin
                col_nx_s = col_r;
              end
            end
            CH_FF: begin
              row_nx_s     = 5'd0;
              col_nx_s     = 5'd0;
              clr_idx_nx_s = 10'd0;
            end
            default: begin
              if (printable_s) begin
                vm_we_nx_s   = 1'b1;
                vm_addr_nx_s = {2'b00, row_r, col_r};
                vm_din_nx_s  = char_data;
                if (col_last_s) begin
                  col_nx_s     = 5'd0;
                  row_nx_s     = next_row(row_r);
                  clr_idx_nx_s = 10'd0;
                end else begin
                  col_nx_s = col_r + 5'd1;
                end
              end else begin
                vm_we_nx_s = 1'b0;
              end
            end
          endcase
        end else begin
          vm_we_nx_s = 1'b0;
        end
      end
      CLR_ROW: begin
        vm_we_nx_s   = 1'b1;
        vm_addr_nx_s = {2'b00, row_r, clr_idx_r[4:0]};
        vm_din_nx_s  = BLANK;
        if (clr_col_last_s) begin
          clr_idx_nx_s = 10'd0;
        end else begin
          clr_idx_nx_s = clr_idx_r + 10'd1;
        end
      end
      CLR_SCREEN: begin
        vm_we_nx_s   = 1'b1;
        vm_addr_nx_s = {2'b00, clr_idx_r};
        vm_din_nx_s  = BLANK;
        if (clr_col_last_s) begin
          if (clr_row_last_s) begin
            clr_idx_nx_s = 10'd0;
          end else begin
            clr_idx_nx_s = {clr_idx_r[9:5] + 5'd1, 5'd0};
          end
        end else begin
          clr_idx_nx_s = clr_idx_r + 10'd1;
        end
      end
      default: begin
        vm_we_nx_s   = 1'b0;
        clr_idx_nx_s = 10'd0;
      end
    endcase
  end

  // Registered datapath: VM port A outputs, cursor and clear index.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      vm_we_r   <= 1'b0;
      vm_addr_r <= 12'd0;
      vm_din_r  <= 8'd0;
      row_r     <= 5'd0;
      col_r     <= 5'd0;
      clr_idx_r <= 10'd0;
    end else begin
      vm_we_r   <= vm_we_nx_s;
      vm_addr_r <= vm_addr_nx_s;
      vm_din_r  <= vm_din_nx_s;
      row_r     <= row_nx_s;
      col_r     <= col_nx_s;
      clr_idx_r <= clr_idx_nx_s;
    end
  end

  // busy is forced low during reset even though the state is parked in a clear.
  assign char_ready = (state_r == IDLE);
  assign busy       = (state_r != IDLE) & ~rst;
  assign vm_we      = vm_we_r;
  assign vm_addr    = vm_addr_r;
  assign vm_din     = vm_din_r;
  assign cur_row    = row_r;
  assign cur_col    = col_r;

endmodule

// File: tb/tb_vm_text_writer.sv
// Directed bench for vm_text_writer: screen/row clears, glyphs, control codes
// and reset in the middle of a screen clear.
module tb_vm_text_writer;

  logic        clk_50mhz = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  char_data = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic        vm_we;
  logic [11:0] vm_addr;
  logic [7:0]  vm_din;
  logic        busy;
  logic [4:0]  cur_row;
  logic [4:0]  cur_col;

  int vectors = 0;
  int miscompares = 0;

  vm_text_writer dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .char_data (char_data),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .vm_we     (vm_we),
    .vm_addr   (vm_addr),
    .vm_din    (vm_din),
    .busy      (busy),
    .cur_row   (cur_row),
    .cur_col   (cur_col)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wr(input logic [11:0] a, input logic [7:0] d);
    return {11'd0, 1'b1, a, d};
  endfunction

  function automatic logic [31:0] obs();
    return {11'd0, vm_we, vm_addr, vm_din};
  endfunction

  task automatic chk_cur(input string tag, input logic [4:0] r, input logic [4:0] c);
    check_vec(tag, 32'({cur_row, cur_col}), 32'({r, c}));
  endtask

  task automatic send(input logic [7:0] b);
    char_data  = b;
    char_valid = 1'b1;
    check_vec("ready", 32'(char_ready), 32'd1);
    @(negedge clk_50mhz);
    char_valid = 1'b0;
  endtask

  task automatic clr_row_check(input logic [4:0] r);
    for (int j = 0; j < 32; j++) begin
      @(negedge clk_50mhz);
      check_vec("row_clr", obs(), wr({2'b00, r, 5'(j)}, 8'h20));
      check_vec("row_rdy", 32'(char_ready), 32'(j == 31));
    end
  endtask

  task automatic screen_clear_check(input string tag);
    for (int i = 0; i < 960; i++) begin
      @(negedge clk_50mhz);
      check_vec(tag, obs(), wr(12'(i), 8'h20));
      if (i == 0 || i == 959) begin
        check_vec({tag, "_busy"}, 32'(busy), 32'(i != 959));
      end
    end
    check_vec({tag, "_rdy"}, 32'(char_ready), 32'd1);
    chk_cur({tag, "_cur"}, 5'd0, 5'd0);
    @(negedge clk_50mhz);
    check_vec({tag, "_we_off"}, 32'(vm_we), 32'd0);
  endtask

  initial begin
    // 1: reset values, then full screen clear after release
    repeat (3) @(negedge clk_50mhz);
    check_vec("rst_vm", obs(), 32'd0);
    check_vec("rst_ctl", 32'({char_ready, busy, cur_row, cur_col}), 32'd0);
    rst = 1'b0;
    screen_clear_check("clr1");

    // 2: single glyph at home
    send(8'h41);
    check_vec("glyph_a", obs(), wr(12'h000, 8'h41));
    chk_cur("cur_a", 5'd0, 5'd1);
    for (int k = 1; k <= 3; k++) begin
      send(8'h0A);
      check_vec("lf_nowr", 32'(vm_we), 32'd0);
      chk_cur("cur_lf", 5'(k), 5'd0);
      clr_row_check(5'(k));
    end

    // 3: a full line back-to-back from (3,0) wraps and clears row 4
    for (int i = 0; i < 32; i++) begin
      char_data  = 8'(8'h41 + i);
      char_valid = 1'b1;
      if (i == 0) check_vec("line_rdy", 32'(char_ready), 32'd1);
      @(negedge clk_50mhz);
      check_vec("line_wr", obs(), wr({2'b00, 5'd3, 5'(i)}, 8'(8'h41 + i)));
    end
    char_valid = 1'b0;
    chk_cur("cur_wrap", 5'd4, 5'd0);
    check_vec("wrap_rdy", 32'(char_ready), 32'd0);
    clr_row_check(5'd4);

    // 4: LF on the last row wraps to row 0
    for (int r = 5; r <= 29; r++) begin
      send(8'h0A);
      clr_row_check(5'(r));
    end
    for (int c = 0; c < 5; c++) begin
      send(8'(8'h61 + c));
      check_vec("r29_wr", obs(), wr({2'b00, 5'd29, 5'(c)}, 8'(8'h61 + c)));
    end
    chk_cur("cur_29_5", 5'd29, 5'd5);
    send(8'h0A);
    check_vec("lf29_nowr", 32'(vm_we), 32'd0);
    chk_cur("cur_lf29", 5'd0, 5'd0);
    clr_row_check(5'd0);

    // 5: backspace, carriage return and discarded bytes
    send(8'h0A);
    clr_row_check(5'd1);
    send(8'h0A);
    clr_row_check(5'd2);
    send(8'h08);
    check_vec("bs0_nowr", 32'(vm_we), 32'd0);
    chk_cur("cur_bs0", 5'd2, 5'd0);
    for (int c = 0; c < 7; c++) begin
      send(8'(8'h30 + c));
      check_vec("r2_wr", obs(), wr({2'b00, 5'd2, 5'(c)}, 8'(8'h30 + c)));
    end
    send(8'h08);
    check_vec("bs_wr", obs(), wr(12'h046, 8'h20));
    chk_cur("cur_bs", 5'd2, 5'd6);
    send(8'h0D);
    check_vec("cr_nowr", 32'(vm_we), 32'd0);
    chk_cur("cur_cr", 5'd2, 5'd0);
    send(8'h7F);
    check_vec("del_nowr", 32'(vm_we), 32'd0);
    chk_cur("cur_del", 5'd2, 5'd0);
    send(8'h01);
    check_vec("ctl_nowr", 32'(vm_we), 32'd0);
    send(8'hFF);
    check_vec("ff_nowr", 32'(vm_we), 32'd0);
    chk_cur("cur_ff", 5'd2, 5'd0);

    // 6: form feed, then reset in the middle of the screen clear
    send(8'h0C);
    check_vec("fflf_nowr", 32'(vm_we), 32'd0);
    chk_cur("cur_home", 5'd0, 5'd0);
    check_vec("ff_state", 32'({char_ready, busy}), 32'b01);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_50mhz);
      check_vec("ff_clr", obs(), wr(12'(i), 8'h20));
    end
    rst = 1'b1;
    #1;
    check_vec("mid_rst_vm", obs(), 32'd0);
    check_vec("mid_rst_ctl", 32'({char_ready, busy, cur_row, cur_col}), 32'd0);
    @(negedge clk_50mhz);
    check_vec("hold_rst_vm", obs(), 32'd0);
    rst = 1'b0;
    screen_clear_check("clr2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
